fetch_unit: RTL and testbench

Instruction fetch/issue sequencer that feeds the control unit. It reads 16-bit instructions from a synchronous instruction memory and presents each one on `instr`, which drives the control unit's `d_in`. It holds `run` high for the control unit's full four-state cycle, retires the instruction when `done` returns, and advances the program counter. It is the initiator side of the `run`/`done` handshake; the control unit is the responder.

---
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory read bus plus the run/done issue
// handshake between the fetch unit (master) and its memory/control-unit
// responders (slave).
interface fetch_unit_if #(
  parameter int ADDR_W = 8
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic [15:0]       instr;
  logic              run;
  logic              done;

  modport master (
    output mem_rd,
    output mem_addr,
    output instr,
    output run,
    input  mem_rdata,
    input  done
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    input  instr,
    input  run,
    output mem_rdata,
    output done
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch/issue sequencer. Reads 16-bit instructions
// from a synchronous memory (data one cycle after the read strobe), holds
// run high while the control unit executes, retires on done and advances pc.
// Optional feature macro: FETCH_HALT_EN -- when defined, the word 16'h0002
// seen in LATCH halts the unit instead of being issued.
module fetch_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] start_addr,
  fetch_unit_if.master      bus,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       inst_count
);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, ISSUE} state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       instr_q;
  logic [15:0]       count_q;
  logic              run_q;
  logic              mem_rd_q;
  logic              busy_q;
  logic              stop_pend;
  logic              stop_req;
`ifdef FETCH_HALT_EN
  logic              halted_q;
`endif

  // Retired-instruction counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A stop seen this cycle counts the same as one already pending.
  assign stop_req = stop | stop_pend;

  // Sequencer FSM; run/mem_rd/busy are registered alongside the state so
  // they change only on clock edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc_q      <= '0;
      instr_q   <= 16'h0000;
      count_q   <= 16'h0000;
      run_q     <= 1'b0;
      mem_rd_q  <= 1'b0;
      busy_q    <= 1'b0;
      stop_pend <= 1'b0;
`ifdef FETCH_HALT_EN
      halted_q  <= 1'b0;
`endif
    end else begin
      if (stop && state != IDLE) stop_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            pc_q     <= start_addr;
            count_q  <= 16'h0000;
`ifdef FETCH_HALT_EN
            halted_q <= 1'b0;
`endif
            mem_rd_q <= 1'b1;
            busy_q   <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          mem_rd_q <= 1'b0;
          if (stop_req) begin
            busy_q    <= 1'b0;
            stop_pend <= 1'b0;
            state     <= IDLE;
          end else begin
            state <= LATCH;
          end
        end
        LATCH: begin
          if (stop_req) begin
            busy_q    <= 1'b0;
            stop_pend <= 1'b0;
            state     <= IDLE;
          end else begin
            instr_q <= bus.mem_rdata;
`ifdef FETCH_HALT_EN
            if (bus.mem_rdata == 16'h0002) begin
              // Reserved format-2 word: stop here, pc keeps the halt address.
              halted_q <= 1'b1;
              busy_q   <= 1'b0;
              state    <= IDLE;
            end else begin
              run_q <= 1'b1;
              state <= ISSUE;
            end
`else
            run_q <= 1'b1;
            state <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          // run stays high until the control unit reports done.
          if (bus.done) begin
            run_q   <= 1'b0;
            pc_q    <= pc_q + PC_ONE;
            count_q <= sat_inc16(count_q);
            if (stop_req) begin
              busy_q    <= 1'b0;
              stop_pend <= 1'b0;
              state     <= IDLE;
            end else begin
              mem_rd_q <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = pc_q;
  assign bus.instr    = instr_q;
  assign bus.run      = run_q;
  assign busy         = busy_q;
  assign pc           = pc_q;
  assign inst_count   = count_q;
`ifdef FETCH_HALT_EN
  assign halted       = halted_q;
`else
  assign halted       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a synchronous memory
// model and a four-state control-unit responder (INITIAL, LOAD, CALCULATE,
// STORE with done in STORE, stalls while run is low).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [7:0]  start_addr;
  logic        busy;
  logic        halted;
  logic [7:0]  pc;
  logic [15:0] inst_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];
  logic [1:0]  cu_st;

  fetch_unit_if #(.ADDR_W(8)) bus ();

  fetch_unit #(.ADDR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .start_addr (start_addr),
    .bus        (bus),
    .busy       (busy),
    .halted     (halted),
    .pc         (pc),
    .inst_count (inst_count)
  );

  always #5 clk = ~clk;

  // synchronous instruction memory
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // control unit responder: 0=INITIAL 1=LOAD 2=CALCULATE 3=STORE
  always @(posedge clk) begin
    if (reset) cu_st <= 2'd0;
    else begin
      case (cu_st)
        2'd0:    if (bus.run) cu_st <= 2'd1;
        2'd1:    cu_st <= 2'd2;
        2'd2:    cu_st <= 2'd3;
        default: cu_st <= 2'd0;
      endcase
    end
  end
  assign bus.done = (cu_st == 2'd3);

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // pulse start for one edge; leaves the unit in FETCH
  task automatic start_op(input logic [7:0] addr);
    start      = 1'b1;
    start_addr = addr;
    tick();
    start      = 1'b0;
  endtask

  // called in a FETCH cycle; runs one instruction through to the next edge
  // after done and checks the run window
  task automatic issue_one(input string tag, input logic [7:0] addr, input logic [15:0] exp);
    int   runs;
    logic stable;
    chk({tag, "_mem_rd"}, {31'd0, bus.mem_rd}, 32'd1);
    chk({tag, "_mem_addr"}, {24'd0, bus.mem_addr}, {24'd0, addr});
    tick();
    chk({tag, "_latch_run"}, {31'd0, bus.run}, 32'd0);
    tick();
    runs   = 0;
    stable = 1'b1;
    while (bus.run && runs < 10) begin
      if (bus.instr !== exp) stable = 1'b0;
      runs++;
      tick();
    end
    chk({tag, "_run_cycles"}, runs, 32'd4);
    chk({tag, "_instr_stable"}, {31'd0, stable}, 32'd1);
  endtask

  initial begin
    int   n;
    logic seen;
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000 | 16'(i);
    mem[8'h10] = 16'h2000; mem[8'h11] = 16'h4021; mem[8'h12] = 16'h0003;
    mem[8'h13] = 16'h0002;
    mem[8'hFF] = 16'h1111; mem[8'h00] = 16'h2222;
    mem[8'h20] = 16'h1234; mem[8'h21] = 16'h5678;
    mem[8'h30] = 16'hABCD; mem[8'h77] = 16'h7777;
    mem[8'h03] = 16'h0100; mem[8'h04] = 16'h0200; mem[8'h05] = 16'h0002;

    reset = 1'b1; start = 1'b0; stop = 1'b0; start_addr = 8'h00;
    tick(); tick();
    reset = 1'b0;

    // reset state
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_run",    {31'd0, bus.run}, 32'd0);
    chk("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("rst_pc",     {24'd0, pc}, 32'd0);
    chk("rst_addr",   {24'd0, bus.mem_addr}, 32'd0);
    chk("rst_instr",  {16'd0, bus.instr}, 32'd0);
    chk("rst_count",  {16'd0, inst_count}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    // three-instruction program from 0x10
    start_op(8'h10);
    chk("p_busy", {31'd0, busy}, 32'd1);
    issue_one("p0", 8'h10, 16'h2000);
    chk("p0_count", {16'd0, inst_count}, 32'd1);
    issue_one("p1", 8'h11, 16'h4021);
    chk("p1_count", {16'd0, inst_count}, 32'd2);
    issue_one("p2", 8'h12, 16'h0003);
    chk("p2_count", {16'd0, inst_count}, 32'd3);
    chk("p2_pc",    {24'd0, pc}, 32'h13);

    // stop while in FETCH of 0x13
    chk("sf_mem_rd", {31'd0, bus.mem_rd}, 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("sf_busy", {31'd0, busy}, 32'd0);
    chk("sf_pc",   {24'd0, pc}, 32'h13);
    seen = 1'b0;
    repeat (4) begin
      if (bus.run) seen = 1'b1;
      tick();
    end
    chk("sf_no_run", {31'd0, seen}, 32'd0);

    // pc wrap from 0xFF
    start_op(8'hFF);
    issue_one("wrap", 8'hFF, 16'h1111);
    chk("wrap_pc",     {24'd0, pc}, 32'h00);
    chk("wrap_addr",   {24'd0, bus.mem_addr}, 32'h00);
    chk("wrap_mem_rd", {31'd0, bus.mem_rd}, 32'd1);
    chk("wrap_count",  {16'd0, inst_count}, 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // stop pulsed during ISSUE of 0x20
    start_op(8'h20);
    tick(); tick();
    chk("si_run", {31'd0, bus.run}, 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n = 0;
    while (bus.run && n < 10) begin
      tick();
      n++;
    end
    chk("si_run_len", n, 32'd3);
    chk("si_busy",  {31'd0, busy}, 32'd0);
    chk("si_pc",    {24'd0, pc}, 32'h21);
    chk("si_count", {16'd0, inst_count}, 32'd1);
    seen = 1'b0;
    repeat (5) begin
      if (bus.mem_rd) seen = 1'b1;
      tick();
    end
    chk("si_no_mem_rd", {31'd0, seen}, 32'd0);

    // start while busy ignored, then reset mid-ISSUE
    start_op(8'h30);
    start = 1'b1;
    start_addr = 8'h77;
    tick();
    start = 1'b0;
    tick();
    chk("rb_run",   {31'd0, bus.run}, 32'd1);
    chk("rb_instr", {16'd0, bus.instr}, 32'hABCD);
    chk("rb_pc",    {24'd0, pc}, 32'h30);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_run",   {31'd0, bus.run}, 32'd0);
    chk("rm_busy",  {31'd0, busy}, 32'd0);
    chk("rm_pc",    {24'd0, pc}, 32'd0);
    chk("rm_instr", {16'd0, bus.instr}, 32'd0);
    chk("rm_count", {16'd0, inst_count}, 32'd0);
    tick();

    // 16'h0002 at 0x05, start at 0x03
    start_op(8'h03);
    issue_one("h0", 8'h03, 16'h0100);
    issue_one("h1", 8'h04, 16'h0200);
`ifdef FETCH_HALT_EN
    chk("h2_addr", {24'd0, bus.mem_addr}, 32'h05);
    tick(); tick();
    chk("h2_halted", {31'd0, halted}, 32'd1);
    chk("h2_run",    {31'd0, bus.run}, 32'd0);
    chk("h2_busy",   {31'd0, busy}, 32'd0);
    chk("h2_pc",     {24'd0, pc}, 32'h05);
    chk("h2_count",  {16'd0, inst_count}, 32'd2);
    chk("h2_instr",  {16'd0, bus.instr}, 32'h0002);
    start_op(8'h03);
    chk("h2_clear",  {31'd0, halted}, 32'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
`else
    issue_one("h2", 8'h05, 16'h0002);
    chk("h2_count",  {16'd0, inst_count}, 32'd3);
    chk("h2_halted", {31'd0, halted}, 32'd0);
    chk("h2_pc",     {24'd0, pc}, 32'h06);
    stop = 1'b1;
    tick();
    stop = 1'b0;
`endif
    chk("end_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
